alu_multiword_seq: RTL and testbench
====================================

// Module: alu_multiword_seq
// PURPOSE
//  Sequencer for the 32-bit ALU: runs one NW-word (default 64-bit) operation as NW
//  back-to-back single-word ALU passes, least-significant word first, chaining carry/borrow.
//  Sits between EXE-stage control and the ALU; owns the ALU's Val1/Val2/EXE_CMD/C while busy.
//  Op encoding is the ALU EXE_CMD encoding; flags are returned as {N,Z,C,V} for the whole operand.
// PARAMETERS
//  W   32  word width; equals the ALU datapath width
//  NW  2   words per operand (>=2); word counter is $clog2(NW) bits
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  start      in   1     request; accepted only when ready=1
//  op         in   4     EXE_CMD code: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC,
//                        0110 AND, 0111 ORR, 1000 EOR
//  cin        in   1     carry-in for ADC/SBC (SBC: 1 = no borrow)
//  opa        in   W*NW  operand 1 (Val1 side)
//  opb        in   W*NW  operand 2 (Val2 side)
//  ready      out  1     1 in IDLE only
//  busy       out  1     1 while ALU passes are in progress
//  done       out  1     one-cycle pulse; result/flags valid from this cycle
//  result     out  W*NW  final result; held until next accepted start
//  flags      out  4     {N,Z,C,V} of the full-width result; held like result
//  bad_op     out  1     sticky with result: op outside the list above
//  alu_val1   out  W     to ALU Val1
//  alu_val2   out  W     to ALU Val2
//  alu_cmd    out  4     to ALU EXE_CMD
//  alu_c      out  1     to ALU C
//  alu_res    in   W     from ALU ALU_Res (combinational, same cycle)
//  alu_status in   4     from ALU Statusbits {N,Z,C,V}
// BEHAVIOUR
//  - Reset: state IDLE, ready=1, busy=0, done=0, result=0, flags=0, bad_op=0, word cnt=0,
//    alu_val1/val2=0, alu_cmd=0000, alu_c=0. Reset mid-operation aborts; no done pulse.
//  - FSM IDLE -> RUN -> DONE -> IDLE. start&&IDLE at edge k: latch opa/opb/op/cin, cnt=0,
//    Zacc=1, bad_op=(op illegal). RUN for NW cycles (k+1..k+NW), DONE in cycle k+NW+1.
//    Latency start-edge to done = NW+1 cycles; throughput one op per NW+2 cycles.
//  - start while not IDLE (incl. DONE) ignored; operands latched only on acceptance.
//  - RUN, word i (cnt=i): alu_val1=opa word i, alu_val2=opb word i. Per-pass command:
//      ADD: i=0 0010, i>0 0011 with alu_c=carry reg   ADC: all 0011, i=0 alu_c=cin
//      SUB: i=0 0100, i>0 0101 with alu_c=~borrow reg SBC: all 0101, i=0 alu_c=cin
//      logic/MOV/MVN: op every pass, alu_c=0
//    alu_c=0 whenever cmd is not 0011/0101. Outside RUN alu_cmd=0000 and val1/val2=0.
//  - End of each RUN cycle: result word i <= alu_res; carry/borrow reg <= alu_status[1]
//    (ALU C out = carry for add, borrow=1 for subtract); Zacc <= Zacc & alu_status[2];
//    cnt <= cnt+1; cnt==NW-1 -> DONE, cnt wraps to 0.
//  - Final flags (written on last pass): N=alu_status[3], Z=Zacc&alu_status[2];
//    arith ops C=alu_status[1], V=alu_status[0]; logic/MOV/MVN C=0, V=0 (ALU C/V not trusted).
//  - bad_op: passes still run with alu_cmd=0000; result=0, flags={0,1,0,0}, bad_op=1.
//  - result/flags/bad_op cleared to 0 on acceptance of next start, updated word-by-word in RUN.
// TESTING
//  1 ADD 0x00000000_FFFFFFFF + 0x1 -> result 0x00000001_00000000, flags 0000, done at k+3
//  2 ADD 0x7FFFFFFF_FFFFFFFF + 0x1 -> 0x80000000_00000000, N=1 V=1 C=0 Z=0
//  3 SUB 0x00000001_00000000 - 0x1 -> 0x00000000_FFFFFFFF; pass1 alu_cmd=0101 alu_c=0;
//    SUB 0x5_0 - 0x5_0 -> 0, Z=1
//  4 EOR 0xFFFF0000_0000FFFF ^ same -> 0, flags {0,1,0,0}; op=1111 -> bad_op=1, result 0
//  5 start held high continuously -> accepted only in IDLE, one done per NW+2 cycles;
//    opa changed mid-op does not alter result
//  6 rst asserted in RUN cycle 2 -> next cycle ready=1, done=0, result=0, alu_cmd=0000

Source files
------------

// File: rtl/alu_multiword_seq.sv
// Multi-word ALU sequencer: runs one NW-word operation as NW single-word passes
// through the external 32-bit ALU, least-significant word first, chaining carry/borrow.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; ready=1, result/flags of last op held
// S_RUN  | one ALU pass per cycle, word index = cnt_q
// S_DONE | one-cycle done pulse; result/flags valid
module alu_multiword_seq #(
    parameter int W  = 32,
    parameter int NW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic            cin,
    input  logic [W*NW-1:0] opa,
    input  logic [W*NW-1:0] opb,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [W*NW-1:0] result,
    output logic [3:0]      flags,
    output logic            bad_op,
    output logic [W-1:0]    alu_val1,
    output logic [W-1:0]    alu_val2,
    output logic [3:0]      alu_cmd,
    output logic            alu_c,
    input  logic [W-1:0]    alu_res,
    input  logic [3:0]      alu_status
);

    localparam int            CW   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADC  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SBC  = 4'b0101;
    localparam logic [3:0] OP_MVN  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W*NW-1:0] opa_q, opb_q;
    logic [3:0]      op_q;
    logic            cin_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            zacc_q;
    logic [W*NW-1:0] result_q;
    logic [3:0]      flags_q;
    logic            bad_op_q;
    logic            is_arith;
    logic            last_pass;
    logic            first_pass;

    function automatic logic op_legal(input logic [3:0] o);
        return (o >= OP_MOV) && (o <= OP_MVN);
    endfunction

    // Only arithmetic commands produce trustworthy C/V from the ALU.
    assign is_arith   = (op_q >= OP_ADD) && (op_q <= OP_SBC);
    assign last_pass  = (cnt_q == LAST);
    assign first_pass = (cnt_q == '0);

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign flags  = flags_q;
    assign bad_op = bad_op_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: IDLE -> RUN on start, RUN for NW passes, DONE for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_pass) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture on acceptance, then per-pass result/carry/zero accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= OP_NONE;
            cin_q    <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b1;
            result_q <= '0;
            flags_q  <= '0;
            bad_op_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        opa_q    <= opa;
                        opb_q    <= opb;
                        op_q     <= op;
                        cin_q    <= cin;
                        cnt_q    <= '0;
                        carry_q  <= 1'b0;
                        zacc_q   <= 1'b1;
                        result_q <= '0;
                        flags_q  <= '0;
                        bad_op_q <= ~op_legal(op);
                    end
                end
                S_RUN: begin
                    result_q[int'(cnt_q)*W +: W] <= bad_op_q ? '0 : alu_res;
                    carry_q <= alu_status[1];
                    zacc_q  <= zacc_q & alu_status[2];
                    cnt_q   <= last_pass ? '0 : cnt_q + 1'b1;
                    if (last_pass) begin
                        if (bad_op_q)
                            flags_q <= 4'b0100;
                        else
                            flags_q <= {alu_status[3],
                                        zacc_q & alu_status[2],
                                        is_arith & alu_status[1],
                                        is_arith & alu_status[0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU drive: per-pass command and carry-in; idle ALU gets zeros outside RUN.
    always_comb begin
        alu_val1 = '0;
        alu_val2 = '0;
        alu_cmd  = OP_NONE;
        alu_c    = 1'b0;
        if (state_q == S_RUN) begin
            alu_val1 = opa_q[int'(cnt_q)*W +: W];
            alu_val2 = opb_q[int'(cnt_q)*W +: W];
            if (!bad_op_q) begin
                case (op_q)
                    OP_ADD: begin
                        alu_cmd = first_pass ? OP_ADD : OP_ADC;
                        alu_c   = first_pass ? 1'b0 : carry_q;
                    end
                    OP_ADC: begin
                        alu_cmd = OP_ADC;
                        alu_c   = first_pass ? cin_q : carry_q;
                    end
                    OP_SUB: begin
                        alu_cmd = first_pass ? OP_SUB : OP_SBC;
                        alu_c   = first_pass ? 1'b0 : ~carry_q;
                    end
                    OP_SBC: begin
                        alu_cmd = OP_SBC;
                        alu_c   = first_pass ? cin_q : ~carry_q;
                    end
                    default: begin
                        alu_cmd = op_q;
                        alu_c   = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq with a behavioural 32-bit ALU attached.
module tb_alu_multiword_seq;

    localparam int W  = 32;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [3:0]      op;
    logic            cin;
    logic [W*NW-1:0] opa, opb;
    logic            ready, busy, done, bad_op;
    logic [W*NW-1:0] result;
    logic [3:0]      flags;
    logic [W-1:0]    alu_val1, alu_val2, alu_res;
    logic [3:0]      alu_cmd, alu_status;
    logic            alu_c;

    int total = 0;
    int bad   = 0;
    int lat;

    alu_multiword_seq #(.W(W), .NW(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .cin        (cin),
        .opa        (opa),
        .opb        (opb),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags      (flags),
        .bad_op     (bad_op),
        .alu_val1   (alu_val1),
        .alu_val2   (alu_val2),
        .alu_cmd    (alu_cmd),
        .alu_c      (alu_c),
        .alu_res    (alu_res),
        .alu_status (alu_status)
    );

    always #5 clk = ~clk;

    // Reference single-word ALU; logic ops return junk C/V on purpose.
    logic [32:0] sum;
    logic        co, vv;
    always_comb begin
        sum     = '0;
        co      = 1'b0;
        vv      = 1'b0;
        alu_res = '0;
        case (alu_cmd)
            4'b0001: begin alu_res = alu_val2;            co = 1'b1; vv = 1'b1; end
            4'b1001: begin alu_res = ~alu_val2;           co = 1'b1; vv = 1'b1; end
            4'b0110: begin alu_res = alu_val1 & alu_val2; co = 1'b1; vv = 1'b1; end
            4'b0111: begin alu_res = alu_val1 | alu_val2; co = 1'b1; vv = 1'b1; end
            4'b1000: begin alu_res = alu_val1 ^ alu_val2; co = 1'b1; vv = 1'b1; end
            4'b0010, 4'b0011: begin
                sum = {1'b0, alu_val1} + {1'b0, alu_val2}
                    + ((alu_cmd == 4'b0011) ? {32'b0, alu_c} : 33'b0);
                alu_res = sum[31:0];
                co = sum[32];
                vv = (alu_val1[31] == alu_val2[31]) && (sum[31] != alu_val1[31]);
            end
            4'b0100, 4'b0101: begin
                sum = {1'b0, alu_val1} - {1'b0, alu_val2}
                    - ((alu_cmd == 4'b0101) ? {32'b0, ~alu_c} : 33'b0);
                alu_res = sum[31:0];
                co = sum[32];
                vv = (alu_val1[31] != alu_val2[31]) && (sum[31] != alu_val1[31]);
            end
            default: alu_res = '0;
        endcase
        alu_status = {alu_res[31], alu_res == '0, co, vv};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!ready && g < 20) begin tick(); g++; end
    endtask

    task automatic launch(input logic [3:0] o, input logic c, input logic [63:0] a, input logic [63:0] b);
        wait_ready();
        op = o; cin = c; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
    endtask

    task automatic run_op(input logic [3:0] o, input logic c, input logic [63:0] a, input logic [63:0] b);
        launch(o, c, a, b);
        wait_done(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'b0; cin = 1'b0; opa = '0; opb = '0;
        tick(); tick();
        chk("rst_ready",  64'(ready),   64'h1);
        chk("rst_busy",   64'(busy),    64'h0);
        chk("rst_done",   64'(done),    64'h0);
        chk("rst_result", result,       64'h0);
        chk("rst_flags",  64'(flags),   64'h0);
        chk("rst_badop",  64'(bad_op),  64'h0);
        chk("rst_cmd",    64'(alu_cmd), 64'h0);
        chk("rst_val1",   64'(alu_val1),64'h0);
        chk("rst_c",      64'(alu_c),   64'h0);
        rst = 1'b0;
        tick();

        // ADD with carry across the word boundary; busy during RUN, done after NW edges.
        launch(4'b0010, 1'b0, 64'h00000000_FFFFFFFF, 64'h1);
        chk("add1_busy",  64'(busy),  64'h1);
        chk("add1_ready", 64'(ready), 64'h0);
        chk("add1_cmd0",  64'(alu_cmd), 64'h2);
        tick();
        chk("add1_cmd1",  64'(alu_cmd), 64'h3);
        chk("add1_c1",    64'(alu_c),   64'h1);
        chk("add1_nodone",64'(done),    64'h0);
        tick();
        chk("add1_done",  64'(done),  64'h1);
        chk("add1_res",   result,     64'h00000001_00000000);
        chk("add1_flags", 64'(flags), 64'h0);
        tick();
        chk("add1_pulse", 64'(done),  64'h0);
        chk("add1_hold",  result,     64'h00000001_00000000);

        // Signed overflow into the top word.
        run_op(4'b0010, 1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1);
        chk("add2_lat",   64'(lat),   64'd2);
        chk("add2_res",   result,     64'h80000000_00000000);
        chk("add2_flags", 64'(flags), 64'h9);

        // SUB with borrow; second pass must be SBC with alu_c=0.
        launch(4'b0100, 1'b0, 64'h00000001_00000000, 64'h1);
        chk("sub1_cmd0", 64'(alu_cmd), 64'h4);
        chk("sub1_c0",   64'(alu_c),   64'h0);
        tick();
        chk("sub1_cmd1", 64'(alu_cmd), 64'h5);
        chk("sub1_c1",   64'(alu_c),   64'h0);
        chk("sub1_val1", 64'(alu_val1),64'h1);
        wait_done(lat);
        chk("sub1_lat",   64'(lat),   64'd1);
        chk("sub1_res",   result,     64'h00000000_FFFFFFFF);
        chk("sub1_flags", 64'(flags), 64'h0);

        run_op(4'b0100, 1'b0, 64'h00000005_00000000, 64'h00000005_00000000);
        chk("sub2_res",   result,     64'h0);
        chk("sub2_flags", 64'(flags), 64'h4);

        // ADC/SBC honour cin on the first pass.
        run_op(4'b0011, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h0);
        chk("adc_res",   result,     64'h0);
        chk("adc_flags", 64'(flags), 64'h6);
        run_op(4'b0101, 1'b0, 64'h5, 64'h2);
        chk("sbc_res",   result,     64'h2);
        chk("sbc_flags", 64'(flags), 64'h0);

        // Logic op: zero across both words, ALU C/V ignored.
        run_op(4'b1000, 1'b0, 64'hFFFF0000_0000FFFF, 64'hFFFF0000_0000FFFF);
        chk("eor_res",   result,     64'h0);
        chk("eor_flags", 64'(flags), 64'h4);
        chk("eor_badop", 64'(bad_op),64'h0);

        // Illegal op: passes run with alu_cmd=0000.
        launch(4'b1111, 1'b0, 64'h12345678_9ABCDEF0, 64'h1);
        chk("bad_cmd",  64'(alu_cmd), 64'h0);
        chk("bad_busy", 64'(busy),    64'h1);
        wait_done(lat);
        chk("bad_res",   result,     64'h0);
        chk("bad_flags", 64'(flags), 64'h4);
        chk("bad_flag",  64'(bad_op),64'h1);

        // MVN clears bad_op; N set, C/V forced low.
        run_op(4'b1001, 1'b0, 64'h0, 64'h0);
        chk("mvn_res",   result,     64'hFFFFFFFF_FFFFFFFF);
        chk("mvn_flags", 64'(flags), 64'h8);
        chk("mvn_badop", 64'(bad_op),64'h0);

        // start held high: opa change mid-op has no effect, one done per NW+2 edges.
        wait_ready();
        op = 4'b0010; cin = 1'b0;
        opa = 64'h00000001_00000002; opb = 64'h00000003_00000004; start = 1'b1;
        tick();
        opa = 64'h00000010_00000000;
        wait_done(lat);
        chk("hold_res1", result, 64'h00000004_00000006);
        lat = 0;
        tick(); lat++;
        chk("hold_idle_ready", 64'(ready), 64'h1);
        chk("hold_idle_done",  64'(done),  64'h0);
        while (!done && lat < 20) begin tick(); lat++; end
        chk("hold_period", 64'(lat), 64'd4);
        chk("hold_res2",   result,   64'h00000013_00000004);
        start = 1'b0;

        // Reset during the second RUN cycle aborts with no done pulse.
        launch(4'b0010, 1'b0, 64'h00000001_00000005, 64'h00000002_00000003);
        tick();
        chk("abort_run", 64'(busy), 64'h1);
        rst = 1'b1;
        tick();
        chk("abort_ready",  64'(ready),   64'h1);
        chk("abort_done",   64'(done),    64'h0);
        chk("abort_result", result,       64'h0);
        chk("abort_cmd",    64'(alu_cmd), 64'h0);
        rst = 1'b0;
        tick();
        chk("abort_nodone", 64'(done),  64'h0);
        chk("abort_idle",   64'(ready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
